// File: rtl/m040_bus_initiator.sv
// 68040-style single-beat bus master: turns a valid/ready request into a
// BR/BG arbitration, a one-cycle TS strobe, and a TIP-framed data phase ended by TA, TEA or timeout.
module m040_bus_initiator #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [1:0]  TT_NORMAL      = 2'b00,
    parameter logic [2:0]  TM_DATA        = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_siz,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        br_n,
    input  logic        bg_n,
    output logic [31:0] a,
    output logic [31:0] d_out,
    output logic        d_oe,
    input  logic [31:0] d_in,
    output logic        ts_n,
    output logic        tip_n,
    output logic        rw,
    output logic [1:0]  siz,
    output logic [1:0]  tt,
    output logic [2:0]  tm,
    input  logic        ta_n,
    input  logic        tea_n
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] SIZ_LINE = 2'b11;

    typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_we;
    logic [1:0]    lat_siz;

    // Ready is decoded from the state register so it drops the instant reset asserts.
    assign req_ready = (state == IDLE) && !rst;

    // NOTE: all state is written with non-blocking assignments so every register
    // in this block samples the pre-edge values, exactly like the hardware flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            lat_siz     <= '0;
            br_n        <= 1'b1;
            ts_n        <= 1'b1;
            tip_n       <= 1'b1;
            d_oe        <= 1'b0;
            rw          <= 1'b1;
            a           <= '0;
            d_out       <= '0;
            siz         <= '0;
            tt          <= TT_NORMAL;
            tm          <= TM_DATA;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr    <= req_addr;
                        lat_wdata   <= req_wdata;
                        lat_we      <= req_we;
                        lat_siz     <= req_siz;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        if (req_siz == SIZ_LINE) begin
                            // Line transfers are refused without touching the bus.
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            br_n  <= 1'b0;
                            state <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (!bg_n) begin
                        ts_n  <= 1'b0;
                        tip_n <= 1'b0;
                        a     <= lat_addr;
                        rw    <= !lat_we;
                        siz   <= lat_siz;
                        if (lat_we) begin
                            d_oe  <= 1'b1;
                            d_out <= lat_wdata;
                        end
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    ts_n  <= 1'b1;
                    count <= '0;
                    state <= DATA;
                end
                DATA: begin
                    count <= count + 1'b1;
                    if (!tea_n || !ta_n || count == COUNT_LAST) begin
                        tip_n     <= 1'b1;
                        d_oe      <= 1'b0;
                        br_n      <= 1'b1;
                        rw        <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        // TEA wins over a simultaneous TA; timeout only when neither arrived.
                        if (!tea_n) begin
                            rsp_err <= 1'b1;
                        end else if (!ta_n) begin
                            if (!lat_we) rsp_rdata <= d_in;
                        end else begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m040_bus_initiator.sv
// Directed bench for m040_bus_initiator: a table of single transfers with a
// scripted responder, plus hand sequences for rejection, grant stall and reset.
module tb_m040_bus_initiator;

    localparam int TO = 8;

    typedef enum {ACK_TA, ACK_TEA, ACK_BOTH, ACK_NONE} ack_e;

    typedef struct {
        logic        we;
        logic [1:0]  siz;
        logic [31:0] addr;
        logic [31:0] wdata;
        ack_e        ack;
        int          delay;     // DATA cycle index (0 = first) at which the ack is driven
        logic [31:0] rdata;     // value on d_in during the ack cycle
        logic        exp_err;
        logic        exp_timeout;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_siz = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        br_n;
    logic        bg_n = 1'b0;
    logic [31:0] a;
    logic [31:0] d_out;
    logic        d_oe;
    logic [31:0] d_in = '0;
    logic        ts_n;
    logic        tip_n;
    logic        rw;
    logic [1:0]  siz;
    logic [1:0]  tt;
    logic [2:0]  tm;
    logic        ta_n = 1'b1;
    logic        tea_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[9];

    m040_bus_initiator #(
        .TIMEOUT_CYCLES(TO),
        .TT_NORMAL(2'b00),
        .TM_DATA(3'b001)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_siz(req_siz), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .br_n(br_n), .bg_n(bg_n), .a(a), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
        .ts_n(ts_n), .tip_n(tip_n), .rw(rw), .siz(siz), .tt(tt), .tm(tm),
        .ta_n(ta_n), .tea_n(tea_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one request at a negedge, lets it be accepted, and returns in ARB.
    task automatic issue_req(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_siz   = v.siz;
        req_wdata = v.wdata;
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        check("br_n_arb", br_n, 1'b0);
    endtask

    // Waits for the address strobe, plays the responder and checks the response.
    task automatic finish_txn(input vec_t v);
        int  n;
        int  k;
        int  bad;
        int  exp_cycles;
        bit  got;
        bit  fire;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ts_n !== 1'b0 && n < 40);
        check("ts_start", ts_n, 1'b0);
        check("tip_addr", tip_n, 1'b0);
        check("addr", a, v.addr);
        check("rw", rw, !v.we);
        check("siz", siz, v.siz);
        check("d_oe_addr", d_oe, v.we);
        if (v.we) check("d_out", d_out, v.wdata);

        k = 0; bad = 0; got = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1;
            end else begin
                if (ts_n !== 1'b1 || tip_n !== 1'b0 || br_n !== 1'b0 || d_oe !== v.we) bad++;
                fire  = (k == v.delay) && (v.ack != ACK_NONE);
                ta_n  = !(fire && (v.ack == ACK_TA  || v.ack == ACK_BOTH));
                tea_n = !(fire && (v.ack == ACK_TEA || v.ack == ACK_BOTH));
                d_in  = fire ? v.rdata : 32'h0BAD_F00D;
                k++;
            end
        end
        ta_n = 1'b1; tea_n = 1'b1; d_in = 32'h0;
        exp_cycles = (v.ack == ACK_NONE) ? TO : v.delay + 1;
        check("rsp_seen", rsp_valid, 1'b1);
        check("data_phase_bad", bad, 0);
        check("data_cycles", k, exp_cycles);
        check("rsp_err", rsp_err, v.exp_err);
        check("rsp_timeout", rsp_timeout, v.exp_timeout);
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("tip_resp", tip_n, 1'b1);
        check("d_oe_resp", d_oe, 1'b0);
        check("br_resp", br_n, 1'b1);
        check("rw_resp", rw, 1'b1);
        @(negedge clk);
        check("rsp_pulse_end", rsp_valid, 1'b0);
        check("ready_after", req_ready, 1'b1);
    endtask

    initial begin
        int   bad;
        vec_t v;
        //           we siz    addr           wdata          ack       dly rdata          err  to   exp_rdata
        vecs[0] = '{1'b0, 2'b00, 32'h0000_1000, 32'h0,         ACK_TA,   2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 2'b01, 32'h3000_0003, 32'h0000_00A5, ACK_TA,   0, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 2'b10, 32'h0000_2002, 32'h0,         ACK_TEA,  2, 32'h1111_1111, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 2'b00, 32'h0000_4000, 32'h0,         ACK_BOTH, 1, 32'h2222_2222, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 2'b00, 32'h0000_5000, 32'h0,         ACK_NONE, 0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 2'b01, 32'h0000_6001, 32'h0,         ACK_TA,   0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
        vecs[6] = '{1'b1, 2'b00, 32'h0000_7000, 32'hCAFE_F00D, ACK_TEA,  3, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
        vecs[7] = '{1'b1, 2'b10, 32'h0000_8000, 32'h0000_BEEF, ACK_NONE, 0, 32'h0,         1'b1, 1'b1, 32'h1234_5678};
        vecs[8] = '{1'b0, 2'b00, 32'h0000_9000, 32'h0,         ACK_TA,  TO-1, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'hA5A5_5A5A};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1'b0);
        check("rst_br", br_n, 1'b1);
        check("rst_ts", ts_n, 1'b1);
        check("rst_tip", tip_n, 1'b1);
        check("rst_doe", d_oe, 1'b0);
        check("rst_rw", rw, 1'b1);
        check("rst_a", a, 32'h0);
        check("rst_tt", tt, 2'b00);
        check("rst_tm", tm, 3'b001);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
        check("rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_post_rst", req_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            issue_req(vecs[i]);
            finish_txn(vecs[i]);
        end

        // Line request: error response one cycle after accept, no bus activity.
        @(negedge clk);
        req_valid = 1'b1; req_siz = 2'b11; req_we = 1'b0; req_addr = 32'h0000_A000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_siz = 2'b00;
        check("line_rsp", rsp_valid, 1'b1);
        check("line_err", rsp_err, 1'b1);
        check("line_to", rsp_timeout, 1'b0);
        check("line_br", br_n, 1'b1);
        check("line_ts", ts_n, 1'b1);
        @(negedge clk);
        check("line_end", {rsp_valid, br_n, ts_n, req_ready}, 4'b0111);

        // Grant withheld for 20 cycles: BR stays asserted, no TS.
        v = vecs[0];
        v.delay = 0;
        v.rdata = 32'h0F0F_0F0F;
        v.exp_rdata = 32'h0F0F_0F0F;
        bg_n = 1'b1;
        issue_req(v);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (br_n !== 1'b0 || ts_n !== 1'b1 || tip_n !== 1'b1) bad++;
        end
        check("no_grant_hold", bad, 0);
        bg_n = 1'b0;
        finish_txn(v);

        // Reset during the data phase of a write.
        v = vecs[1];
        issue_req(v);
        bad = 0;
        do begin
            @(negedge clk);
            bad++;
        end while (ts_n !== 1'b0 && bad < 40);
        @(negedge clk);
        check("pre_rst_in_data", {tip_n, d_oe}, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bus", {ts_n, tip_n, br_n, d_oe}, 4'b1110);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        check("post_rst_quiet", bad, 0);

        // A normal read after the aborted transfer.
        v = vecs[5];
        v.rdata = 32'h7654_3210;
        v.exp_rdata = 32'h7654_3210;
        issue_req(v);
        finish_txn(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
